reg_dump_reader: RTL
====================

Name: reg_dump_reader

Overview:
- Debug/observability reader for the LC-3 8x16 register file. On a start pulse it drives the file's read-select input over R0..R(NUM_REGS-1) and captures each combinational read value.
- Each captured word goes out on a valid/ready stream tagged with its register index, for the debug UART/trace path.
- Read-only: never drives the register file's write port.

Parameters:
- NUM_REGS, 8, number of registers scanned (power of two, 2..8)
- ADDR_W, 3, width of register select; NUM_REGS <= 2**ADDR_W
- DATA_W, 16, register data width

Ports:
- clk  input  1  system clock; all state updates on posedge clk
- reset  input  1  synchronous, active-high reset
- start  input  1  request a full dump; sampled only in IDLE
- rd_sel  output  ADDR_W  register select driven to the register-file read port
- rd_data  input  DATA_W  combinational register-file read data for rd_sel
- out_valid  output  1  out_data/out_idx/out_last valid
- out_ready  input  1  downstream accepts the word when high with out_valid
- out_data  output  DATA_W  captured register value
- out_idx  output  ADDR_W+1  register index of out_data (checksum word uses NUM_REGS)
- out_last  output  1  final word of the dump
- busy  output  1  high from the cycle after start is accepted until the last word is accepted
- done  output  1  one-cycle pulse the cycle after the final handshake

Behaviour:
- Reset (synchronous, active-high, dominates all inputs):
  - state=IDLE, idx=0, rd_sel=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
  - Reset mid-dump aborts immediately; no further words and no done pulse.
- FSM states: IDLE, READ, SEND.
- IDLE:
  - rd_sel=0.
  - start=1 -> idx<=0, busy<=1, state<=READ.
  - start=0 -> stay.
- READ (exactly one cycle):
  - rd_sel=idx.
  - out_data<=rd_data; out_idx<=idx; out_last<=(idx==NUM_REGS-1) (see feature); out_valid<=1; state<=SEND.
- SEND:
  - out_data/out_idx/out_last held stable while out_valid=1 and out_ready=0. No timeout.
  - Handshake is out_valid & out_ready in the same cycle.
  - On handshake, non-last word: idx<=idx+1, out_valid<=0, state<=READ.
  - On handshake, last word: out_valid<=0, out_last<=0, busy<=0, done<=1 for one cycle, state<=IDLE.
- Latency and throughput:
  - Start accepted in cycle T -> READ in T+1 -> out_valid=1 in T+2.
  - Steady-state throughput is one word per 2 cycles with out_ready held high.
- out_valid never deasserts without a handshake, except on reset.
- start while busy (READ/SEND) is ignored, not queued.
- start in the same cycle as done=1 (state already IDLE) is accepted normally.
- Coherency:
  - Each word is a snapshot taken in its READ cycle.
  - A register-file write to a not-yet-read register during a dump is visible in the dump.
  - A write to an already-read register is not visible. No stall or lock is applied.
- idx is ADDR_W+1 bits wide, so it never wraps within a dump.
- done is 0 in every cycle other than the one pulse.

Optional Feature:
- Macro: REG_DUMP_CHECKSUM_EN
- Defined:
  - After register NUM_REGS-1 is accepted, one extra word is emitted with out_data = mod-2**DATA_W sum of all captured register words, out_idx=NUM_REGS, out_last=1.
  - Register NUM_REGS-1 then has out_last=0.
  - The accumulator clears on start acceptance and on reset, and adds rd_data in every READ cycle.
  - The checksum word is emitted from a dedicated READ-equivalent cycle, so it keeps the 2-cycle cadence.
  - done follows the checksum handshake.
- Undefined: no accumulator, exactly NUM_REGS words, out_last on register NUM_REGS-1.

Test Plan:
- Preload R0..R7=0x1000..0x1007, out_ready=1, start pulse at T:
  - out_valid first at T+2.
  - Words 0x1000..0x1007 with out_idx 0..7, one every 2 cycles.
  - out_last only on idx 7; done=1 one cycle after the idx-7 handshake; busy low the same cycle.
- Backpressure: out_ready=0 for 5 cycles while word idx 3 is valid:
  - out_data=0x1003, out_idx=3, out_valid=1 all stable.
  - Proceeds to idx 4 two cycles after out_ready rises.
- start re-pulsed during word idx 2: ignored; single dump of 8 words; exactly one done pulse.
- Reset asserted while idx 4 is in SEND:
  - Next cycle out_valid=0, busy=0, rd_sel=0, state IDLE; no done.
  - A new start gives a full dump from idx 0.
- Mid-dump write: while word idx 1 is in SEND, write R5=0xBEEF. Dump shows idx 5 = 0xBEEF.
- With REG_DUMP_CHECKSUM_EN:
  - R0..R7=0x1000..0x1007 -> 9th word 0x801C, out_idx=8, out_last=1.
  - All registers = 0xFFFF -> checksum 0xFFF8 (wrap).

Source files
------------

// File: rtl/reg_dump_reader_if.sv
// Output word stream of the register-file dump reader.
// The master drives a captured register word with its index and a last flag.
// The slave (debug UART / trace path) returns out_ready.
interface reg_dump_reader_if #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 16
);

   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W:0]   out_idx;
   logic              out_last;

   modport master (
      output out_valid,
      output out_data,
      output out_idx,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      input  out_idx,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/reg_dump_reader.sv
// Debug reader for the LC-3 register file.
// On start, the reader walks rd_sel over R0..R(NUM_REGS-1) and snapshots each
// combinational read word in its READ cycle. Each word is then presented on a
// valid/ready stream together with its index.
// The reader is read-only: it never touches the register-file write port.
//
// Optional build macro REG_DUMP_CHECKSUM_EN appends one extra word after the
// last register. That word carries the modulo-2**DATA_W sum of all captured
// words, with out_idx = NUM_REGS and out_last = 1.
module reg_dump_reader #(
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = 3,
   parameter int DATA_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rd_sel,
   input  logic [DATA_W-1:0] rd_data,
   reg_dump_reader_if.master out_if,
   output logic              busy,
   output logic              done
);

   // The index is one bit wider than the select, so it can reach NUM_REGS
   // (the checksum slot) and never wraps within a dump.
   localparam int IDX_W = ADDR_W + 1;
   localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] NUM_IDX  = IDX_W'(NUM_REGS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [IDX_W-1:0]  idx;

   // Stage 1 holding register: the word currently offered downstream.
   logic              vld_p1;
   logic [DATA_W-1:0] data_p1;
   logic [IDX_W-1:0]  idx_p1;
   logic              last_p1;

   logic              busy_q;
   logic              done_q;
   logic              hs;

`ifdef REG_DUMP_CHECKSUM_EN
   // Stage 0 running sum of every word captured so far in this dump.
   logic [DATA_W-1:0] csum_p0;

   // Modulo-2**DATA_W accumulation; the carry out is discarded on purpose.
   function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
      logic [DATA_W:0] full;
      full = {1'b0, a} + {1'b0, b};
      return full[DATA_W-1:0];
   endfunction
`endif

   // The select only addresses real registers; the checksum slot reads R0
   // harmlessly, so it is forced to zero there for a quiet read port.
   function automatic logic [ADDR_W-1:0] sel_of(input logic [IDX_W-1:0] i);
      if (i < NUM_IDX) begin
         return i[ADDR_W-1:0];
      end
      return '0;
   endfunction

   assign hs = vld_p1 & out_if.out_ready;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the register-file read select.
   always_comb begin
      state_nxt = state;
      rd_sel    = '0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = READ;
            end
         end
         READ: begin
            rd_sel    = sel_of(idx);
            state_nxt = SEND;
         end
         SEND: begin
            rd_sel = sel_of(idx);
            if (hs) begin
               state_nxt = last_p1 ? IDLE : READ;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Capture, index advance, status flags and the checksum accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx     <= '0;
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         idx_p1  <= '0;
         last_p1 <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum_p0 <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx    <= '0;
                  busy_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                  csum_p0 <= '0;
`endif
               end
            end
            READ: begin
               vld_p1 <= 1'b1;
               idx_p1 <= idx;
`ifdef REG_DUMP_CHECKSUM_EN
               if (idx == NUM_IDX) begin
                  data_p1 <= csum_p0;
                  last_p1 <= 1'b1;
               end else begin
                  data_p1 <= rd_data;
                  csum_p0 <= wrap_add(csum_p0, rd_data);
                  last_p1 <= 1'b0;
               end
`else
               data_p1 <= rd_data;
               last_p1 <= (idx == LAST_REG);
`endif
            end
            SEND: begin
               if (hs) begin
                  vld_p1 <= 1'b0;
                  if (last_p1) begin
                     last_p1 <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     idx <= idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               vld_p1 <= 1'b0;
            end
         endcase
      end
   end

   assign out_if.out_valid = vld_p1;
   assign out_if.out_data  = data_p1;
   assign out_if.out_idx   = idx_p1;
   assign out_if.out_last  = last_p1;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule
